// File: rtl/sfm_stream_strb_gen_pkg.sv
// Shared types for the misaligned 2D stream strobe generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Config fields are carried at the package widths below; the top-level
// ADDR_WIDTH / LEN_WIDTH parameters must not exceed them.
package sfm_stream_pkg;

   localparam int unsigned CFG_ADDR_W = 32;
   localparam int unsigned CFG_LEN_W  = 16;

   typedef struct packed {
      logic [CFG_ADDR_W-1:0] base;     // byte base address
      logic [CFG_LEN_W-1:0]  len;      // bytes per row
      logic [CFG_LEN_W-1:0]  rows;     // number of rows
      logic [CFG_ADDR_W-1:0] stride;   // byte distance between row starts
   } strb_cfg_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } strb_state_e;

endpackage

// File: rtl/sfm_stream_strb_gen_if.sv
// Bundle of controller-side config and stream-side strobe signals for all channels.
// Latency: n/a (wiring only).
// Backpressure: n/a; the handshake is observed, never driven, by the generator.
//
// Ports: clear_i, start_i, base_addr_i, row_len_i, nb_rows_i, row_stride_i,
// valid_i, ready_i in; aligned_base_o, strb_o, row_last_o, last_o, busy_o,
// done_o, err_o out (plus stall_cnt_o / beat_cnt_o with SFM_STREAM_STATS_EN).
// master = controller/bench side, slave = strobe generator side.
interface sfm_stream_strb_gen_if #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned NB_CHAN    = 2
);
   localparam int unsigned BW = DATA_WIDTH / 8;

   logic                          clear_i;
   logic [NB_CHAN-1:0]            start_i;
   logic [NB_CHAN*ADDR_WIDTH-1:0] base_addr_i;
   logic [NB_CHAN*LEN_WIDTH-1:0]  row_len_i;
   logic [NB_CHAN*LEN_WIDTH-1:0]  nb_rows_i;
   logic [NB_CHAN*ADDR_WIDTH-1:0] row_stride_i;
   logic [NB_CHAN-1:0]            valid_i;
   logic [NB_CHAN-1:0]            ready_i;
   logic [NB_CHAN*ADDR_WIDTH-1:0] aligned_base_o;
   logic [NB_CHAN*BW-1:0]         strb_o;
   logic [NB_CHAN-1:0]            row_last_o;
   logic [NB_CHAN-1:0]            last_o;
   logic [NB_CHAN-1:0]            busy_o;
   logic [NB_CHAN-1:0]            done_o;
   logic [NB_CHAN-1:0]            err_o;
`ifdef SFM_STREAM_STATS_EN
   logic [NB_CHAN*32-1:0]         stall_cnt_o;
   logic [NB_CHAN*32-1:0]         beat_cnt_o;
`endif

   modport master (
      output clear_i, start_i, base_addr_i, row_len_i, nb_rows_i, row_stride_i,
             valid_i, ready_i,
`ifdef SFM_STREAM_STATS_EN
      input  stall_cnt_o, beat_cnt_o,
`endif
      input  aligned_base_o, strb_o, row_last_o, last_o, busy_o, done_o, err_o
   );

   modport slave (
      input  clear_i, start_i, base_addr_i, row_len_i, nb_rows_i, row_stride_i,
             valid_i, ready_i,
`ifdef SFM_STREAM_STATS_EN
      output stall_cnt_o, beat_cnt_o,
`endif
      output aligned_base_o, strb_o, row_last_o, last_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/sfm_stream_strb_gen_chan.sv
// One channel: FSM + beat/row counters + byte strobe for a misaligned 2D stream.
// Latency: strobe/flags combinational from registered state (0 cycles vs beat); done/err 1 cycle after last handshake.
// Backpressure: advances only on i_valid & i_ready; stalls hold strobe and flags stable.
//
// Optional SFM_STREAM_STATS_EN adds o_stall_cnt / o_beat_cnt saturating counters.
// Ports: clk_i, rst_ni (sync, active low), i_clear, i_start, i_cfg, i_valid,
// i_ready in; o_aligned_base, o_strb, o_row_last, o_last, o_busy, o_done, o_err out.
module sfm_strb_chan
   import sfm_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    i_clear,
   input  logic                    i_start,
   input  strb_cfg_t               i_cfg,
   input  logic                    i_valid,
   input  logic                    i_ready,
   output logic [CFG_ADDR_W-1:0]   o_aligned_base,
   output logic [DATA_WIDTH/8-1:0] o_strb,
   output logic                    o_row_last,
   output logic                    o_last,
   output logic                    o_busy,
   output logic                    o_done,
`ifdef SFM_STREAM_STATS_EN
   output logic [31:0]             o_stall_cnt,
   output logic [31:0]             o_beat_cnt,
`endif
   output logic                    o_err
);
   localparam int unsigned BW = DATA_WIDTH / 8;
   localparam int unsigned OW = $clog2(BW);
   // One extra bit so (off + L + BW-1) can never wrap.
   localparam int unsigned CW = CFG_LEN_W + 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t                 CNT_ONE = CW'(1);
   localparam logic [CFG_LEN_W-1:0] LEN_ONE = CFG_LEN_W'(1);
   localparam logic [OW-1:0]        OW_ONE  = OW'(1);
   localparam logic [OW:0]          HI_ONE  = (OW+1)'(1);
   localparam logic [OW:0]          HI_BW   = (OW+1)'(BW);

   strb_state_e           r_state;
   cnt_t                  r_beat_cnt;
   cnt_t                  r_row_beats;
   logic [CFG_LEN_W-1:0]  r_row_cnt;
   logic [CFG_LEN_W-1:0]  r_len;
   logic [CFG_LEN_W-1:0]  r_rows;
   logic [OW-1:0]         r_row_off;
   logic [OW-1:0]         r_stride_lo;
   logic [CFG_ADDR_W-1:0] r_aligned_base;
   logic                  r_done;
   logic                  r_err;

   logic                  w_active;
   logic                  w_hs;
   logic                  w_row_first;
   logic                  w_row_end;
   logic                  w_xfer_end;
   logic                  w_cfg_bad;
   logic [OW-1:0]         w_lo;
   logic [OW-1:0]         w_end_m1;
   logic [OW:0]           w_hi;
   logic [OW-1:0]         w_next_off;
   logic                  w_unused_stride;

   // Only the sub-word part of the stride matters: whole words move the
   // address, which the downstream streamer handles.
   assign w_unused_stride = ^i_cfg.stride[CFG_ADDR_W-1:OW];

   function automatic cnt_t f_row_beats(input logic [OW-1:0] off,
                                        input logic [CFG_LEN_W-1:0] len);
      cnt_t w_sum;
      w_sum = cnt_t'(off) + cnt_t'(len) + cnt_t'(BW - 1);
      return w_sum >> OW;
   endfunction

   assign w_active    = (r_state == ACTIVE);
   assign w_hs        = w_active & i_valid & i_ready;
   assign w_row_first = (r_beat_cnt == '0);
   assign w_row_end   = (r_beat_cnt == (r_row_beats - CNT_ONE));
   assign w_xfer_end  = w_row_end & (r_row_cnt == (r_rows - LEN_ONE));
   assign w_cfg_bad   = (i_cfg.len == '0) | (i_cfg.rows == '0);

   // Last byte of the row modulo BW; wrap of the OW-bit sum is intentional.
   assign w_end_m1    = r_row_off + r_len[OW-1:0] - OW_ONE;
   assign w_lo        = w_row_first ? r_row_off : '0;
   assign w_hi        = w_row_end ? ({1'b0, w_end_m1} + HI_ONE) : HI_BW;
   assign w_next_off  = r_row_off + r_stride_lo;

   always_comb begin
      o_strb = '0;
      for (int i = 0; i < BW; i++) begin
         if (w_active && (i >= int'(w_lo)) && (i < int'(w_hi))) begin
            o_strb[i] = 1'b1;
         end
      end
   end

   assign o_busy         = w_active;
   assign o_row_last     = w_active & w_row_end;
   assign o_last         = w_active & w_xfer_end;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_aligned_base = r_aligned_base;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || i_clear) begin
         r_state        <= IDLE;
         r_beat_cnt     <= '0;
         r_row_beats    <= '0;
         r_row_cnt      <= '0;
         r_len          <= '0;
         r_rows         <= '0;
         r_row_off      <= '0;
         r_stride_lo    <= '0;
         r_aligned_base <= '0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_aligned_base <= {i_cfg.base[CFG_ADDR_W-1:OW], {OW{1'b0}}};
                  r_row_off      <= i_cfg.base[OW-1:0];
                  r_len          <= i_cfg.len;
                  r_rows         <= i_cfg.rows;
                  r_stride_lo    <= i_cfg.stride[OW-1:0];
                  r_row_beats    <= f_row_beats(i_cfg.base[OW-1:0], i_cfg.len);
                  r_beat_cnt     <= '0;
                  r_row_cnt      <= '0;
                  if (w_cfg_bad) begin
                     // Empty transfer: report completion with error, emit no beats.
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (w_hs) begin
                  if (w_xfer_end) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else if (w_row_end) begin
                     // New row: offset shifts by the sub-word stride, beat count redone.
                     r_row_off   <= w_next_off;
                     r_row_beats <= f_row_beats(w_next_off, r_len);
                     r_beat_cnt  <= '0;
                     r_row_cnt   <= r_row_cnt + LEN_ONE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + CNT_ONE;
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SFM_STREAM_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_hs_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || i_clear) begin
         r_stall_cnt <= '0;
         r_hs_cnt    <= '0;
      end else if ((r_state == IDLE) && i_start) begin
         r_stall_cnt <= '0;
         r_hs_cnt    <= '0;
      end else begin
         if (w_active && i_valid && !i_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (w_hs && (r_hs_cnt != '1)) begin
            r_hs_cnt <= r_hs_cnt + 32'd1;
         end
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_beat_cnt  = r_hs_cnt;
`endif

endmodule

// File: rtl/sfm_stream_strb_gen.sv
// NB_CHAN-channel byte-strobe generator for misaligned 2D TCDM streams.
// Latency: strobe/flags 0 cycles vs beat; done_o/err_o 1 cycle after last handshake (or after start for empty config).
// Backpressure: each channel advances only on its valid_i & ready_i; stalled channels hold outputs.
//
// Optional feature macro: SFM_STREAM_STATS_EN (stall_cnt_o / beat_cnt_o on the interface).
// Ports: clk_i, rst_ni (sync, active low), bus (sfm_stream_strb_gen_if.slave).
module sfm_stream_strb_gen
   import sfm_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned NB_CHAN    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   sfm_stream_strb_gen_if.slave  bus
);
   localparam int unsigned BW = DATA_WIDTH / 8;

   for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
      strb_cfg_t             w_cfg;
      logic [CFG_ADDR_W-1:0] w_aligned;

      assign w_cfg.base   = CFG_ADDR_W'(bus.base_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]);
      assign w_cfg.len    = CFG_LEN_W'(bus.row_len_i[c*LEN_WIDTH +: LEN_WIDTH]);
      assign w_cfg.rows   = CFG_LEN_W'(bus.nb_rows_i[c*LEN_WIDTH +: LEN_WIDTH]);
      assign w_cfg.stride = CFG_ADDR_W'(bus.row_stride_i[c*ADDR_WIDTH +: ADDR_WIDTH]);

      sfm_strb_chan #(
         .DATA_WIDTH (DATA_WIDTH)
      ) i_chan (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .i_clear        (bus.clear_i),
         .i_start        (bus.start_i[c]),
         .i_cfg          (w_cfg),
         .i_valid        (bus.valid_i[c]),
         .i_ready        (bus.ready_i[c]),
         .o_aligned_base (w_aligned),
         .o_strb         (bus.strb_o[c*BW +: BW]),
         .o_row_last     (bus.row_last_o[c]),
         .o_last         (bus.last_o[c]),
         .o_busy         (bus.busy_o[c]),
         .o_done         (bus.done_o[c]),
`ifdef SFM_STREAM_STATS_EN
         .o_stall_cnt    (bus.stall_cnt_o[c*32 +: 32]),
         .o_beat_cnt     (bus.beat_cnt_o[c*32 +: 32]),
`endif
         .o_err          (bus.err_o[c])
      );

      assign bus.aligned_base_o[c*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(w_aligned);
   end

endmodule
